k6502_sequencer: RTL and testbench



---
 rtl/k6502_pkg.sv | 76 +++++++
 rtl/k6502_decode.sv | 84 ++++++++
 rtl/k6502_sequencer.sv | 107 ++++++++++
 tb/tb_k6502_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/k6502_pkg.sv
// Shared types for the k6502 sequencer: control word, T-state encoding and opcode constants.
package k6502_pkg;

  typedef struct packed {
    logic pc_inc;
    logic pc_adl;
    logic pc_adh;
    logic adl_abl;
    logic adh_abh;
    logic dl_adl;
    logic dl_adh;
    logic zero_adh;
    logic add_adl;
    logic dl_db;
    logic ac_db;
    logic ac_sb;
    logic ac_out_sb;
    logic x_sb;
    logic y_sb;
    logic sb_x;
    logic sb_y;
    logic sb_add;
    logic db_add;
    logic z_add;
  } control_signals_t;

  // Encoding doubles as the externally visible t_state value.
  typedef enum logic [2:0] {
    T_JAM   = 3'd0,
    T_FETCH = 3'd1,
    T_T2    = 3'd2,
    T_T3    = 3'd3,
    T_T4    = 3'd4
  } t_state_e;

  typedef enum logic [1:0] {
    NS_HOLD,
    NS_ADVANCE,
    NS_FETCH,
    NS_JAM
  } next_state_class_e;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TYA     = 8'h98;

  function automatic logic is_lda(input logic [7:0] op);
    return (op == OP_LDA_IMM) || (op == OP_LDA_ZP) || (op == OP_LDA_ABS);
  endfunction

  // 01: transfer into an index register, 10: transfer into AC, 00: none.
  function automatic logic [1:0] xfer_class(input logic [7:0] op);
    logic [1:0] cls;
    cls = 2'b00;
    if ((op == OP_TAX) || (op == OP_TAY)) cls = 2'b01;
    if ((op == OP_TXA) || (op == OP_TYA)) cls = 2'b10;
    return cls;
  endfunction

  function automatic control_signals_t pc_read(input logic inc);
    control_signals_t c;
    c = '0;
    c.pc_adl  = 1'b1;
    c.pc_adh  = 1'b1;
    c.adl_abl = 1'b1;
    c.adh_abh = 1'b1;
    c.pc_inc  = inc;
    return c;
  endfunction

endpackage

// File: rtl/k6502_decode.sv
// Combinational {ir, T-state} -> {control word, next-state class} table.
// With K6502_JAM_EN defined, undefined opcodes request the JAM state after T2.
module k6502_decode
  import k6502_pkg::*;
(
  input  logic [7:0]        ir,
  input  t_state_e          state,
  output control_signals_t  ctl,
  output next_state_class_e next_class
);

  always_comb begin
    ctl        = '0;
    next_class = NS_FETCH;
    case (state)
      T_FETCH: begin
        ctl        = pc_read(1'b1);
        next_class = NS_ADVANCE;
      end
      T_T2: begin
        case (ir)
          OP_LDA_IMM: ctl = pc_read(1'b1);
          OP_LDA_ZP, OP_LDA_ABS: begin
            ctl        = pc_read(1'b1);
            next_class = NS_ADVANCE;
          end
          OP_TAX: begin
            ctl           = pc_read(1'b0);
            ctl.ac_out_sb = 1'b1;
            ctl.sb_x      = 1'b1;
          end
          OP_TAY: begin
            ctl           = pc_read(1'b0);
            ctl.ac_out_sb = 1'b1;
            ctl.sb_y      = 1'b1;
          end
          OP_TXA: begin
            ctl       = pc_read(1'b0);
            ctl.x_sb  = 1'b1;
            ctl.ac_sb = 1'b1;
          end
          OP_TYA: begin
            ctl       = pc_read(1'b0);
            ctl.y_sb  = 1'b1;
            ctl.ac_sb = 1'b1;
          end
          OP_NOP: ctl = pc_read(1'b0);
          default: begin
            ctl = pc_read(1'b0);
`ifdef K6502_JAM_EN
            next_class = NS_JAM;
`endif
          end
        endcase
      end
      T_T3: begin
        if (ir == OP_LDA_ZP) begin
          ctl.dl_adl   = 1'b1;
          ctl.adl_abl  = 1'b1;
          ctl.zero_adh = 1'b1;
          ctl.adh_abh  = 1'b1;
        end else if (ir == OP_LDA_ABS) begin
          // Low address byte goes through the adder so T4 can put it on ADL.
          ctl        = pc_read(1'b1);
          ctl.dl_db  = 1'b1;
          ctl.db_add = 1'b1;
          ctl.z_add  = 1'b1;
          next_class = NS_ADVANCE;
        end
      end
      T_T4: begin
        if (ir == OP_LDA_ABS) begin
          ctl.dl_adh  = 1'b1;
          ctl.adh_abh = 1'b1;
          ctl.add_adl = 1'b1;
          ctl.adl_abl = 1'b1;
        end
      end
      T_JAM:   next_class = NS_HOLD;
      default: next_class = NS_FETCH;
    endcase
  end

endmodule

// File: rtl/k6502_sequencer.sv
// k6502 T-state sequencer: state/IR/pend registers, rdy masking and LDA retirement.
// Optional feature macro: K6502_JAM_EN (undefined opcodes lock up in JAM until reset).
module k6502_sequencer
  import k6502_pkg::*;
#(
  parameter logic [7:0] NOP_OPCODE = 8'hEA
) (
  input  logic             ph0,
  input  logic             reset,
  input  logic             rdy,
  input  logic [7:0]       opcode,
  output control_signals_t ctl,
  output logic             sync,
  output logic [2:0]       t_state,
  output logic             jammed
);

  t_state_e          state, state_nxt;
  logic [7:0]        ir, ir_nxt;
  logic              pend_lda, pend_lda_nxt;
  logic [1:0]        pend_xfer, pend_xfer_nxt;
  control_signals_t  dec_ctl;
  next_state_class_e next_class;

  k6502_decode u_decode (
    .ir         (ir),
    .state      (state),
    .ctl        (dec_ctl),
    .next_class (next_class)
  );

  always_ff @(posedge ph0) begin
    if (reset) begin
      state     <= T_FETCH;
      ir        <= NOP_OPCODE;
      pend_lda  <= 1'b0;
      pend_xfer <= 2'b00;
    end else begin
      state     <= state_nxt;
      ir        <= ir_nxt;
      pend_lda  <= pend_lda_nxt;
      pend_xfer <= pend_xfer_nxt;
    end
  end

  // A FETCH consumes the pending bits; the last cycle of an instruction re-arms them.
  always_comb begin
    state_nxt     = state;
    ir_nxt        = ir;
    pend_lda_nxt  = pend_lda;
    pend_xfer_nxt = pend_xfer;
    if (rdy) begin
      if (state == T_FETCH) begin
        ir_nxt        = opcode;
        pend_lda_nxt  = 1'b0;
        pend_xfer_nxt = 2'b00;
      end
      case (next_class)
        NS_ADVANCE: state_nxt = t_state_e'(state + 3'd1);
        NS_FETCH: begin
          state_nxt     = T_FETCH;
          pend_lda_nxt  = is_lda(ir);
          pend_xfer_nxt = xfer_class(ir);
        end
`ifdef K6502_JAM_EN
        NS_JAM: state_nxt = T_JAM;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ctl = dec_ctl;
    if ((state == T_FETCH) && pend_lda) begin
      ctl.dl_db = 1'b1;
      ctl.ac_db = 1'b1;
    end
    // Stalled cycles keep bus enables but must not load or increment anything.
    if (!rdy) begin
      ctl.pc_inc  = 1'b0;
      ctl.adl_abl = 1'b0;
      ctl.adh_abh = 1'b0;
      ctl.ac_db   = 1'b0;
      ctl.ac_sb   = 1'b0;
      ctl.sb_x    = 1'b0;
      ctl.sb_y    = 1'b0;
      ctl.sb_add  = 1'b0;
      ctl.z_add   = 1'b0;
      ctl.db_add  = 1'b0;
    end
    sync = (state == T_FETCH);
    if (reset) begin
      ctl  = '0;
      sync = 1'b0;
    end
  end

  assign t_state = state;

`ifdef K6502_JAM_EN
  assign jammed = (state == T_JAM);
`else
  assign jammed = 1'b0;
`endif

endmodule

// File: tb/tb_k6502_sequencer.sv
// Scoreboard bench for k6502_sequencer: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_k6502_sequencer;
  import k6502_pkg::*;

  typedef struct packed {
    logic [2:0]       t;
    logic             s;
    logic             j;
    control_signals_t c;
  } exp_t;

  logic             ph0;
  logic             reset;
  logic             rdy;
  logic [7:0]       opcode;
  control_signals_t ctl;
  logic             sync;
  logic [2:0]       t_state;
  logic             jammed;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run;
  int    tests_failed;

  k6502_sequencer #(.NOP_OPCODE(8'hEA)) dut (
    .ph0     (ph0),
    .reset   (reset),
    .rdy     (rdy),
    .opcode  (opcode),
    .ctl     (ctl),
    .sync    (sync),
    .t_state (t_state),
    .jammed  (jammed)
  );

  initial ph0 = 1'b0;
  always #5 ph0 = ~ph0;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic control_signals_t pc_rd(input logic inc);
    control_signals_t c;
    c = '0;
    c.pc_adl  = 1'b1;
    c.pc_adh  = 1'b1;
    c.adl_abl = 1'b1;
    c.adh_abh = 1'b1;
    c.pc_inc  = inc;
    return c;
  endfunction

  // Drives one cycle of inputs and queues what the outputs must show during that cycle.
  task automatic apply_stimulus(input logic r, input logic rd, input logic [7:0] op,
                                input logic [2:0] t, input logic s, input logic j,
                                input control_signals_t c, input string nm);
    exp_t e;
    reset  = r;
    rdy    = rd;
    opcode = op;
    e.t = t;
    e.s = s;
    e.j = j;
    e.c = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge ph0);
    #1;
  endtask

  task automatic check_output(input exp_t e, input string nm);
    tests_run++;
    if (t_state !== e.t || sync !== e.s || jammed !== e.j || ctl !== e.c) begin
      tests_failed++;
      $display("[TB] FAIL %s: got t_state=%0d sync=%b jammed=%b ctl=%05h, want t_state=%0d sync=%b jammed=%b ctl=%05h",
               nm, t_state, sync, jammed, ctl, e.t, e.s, e.j, e.c);
    end
  endtask

  always @(negedge ph0) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_output(e, nm);
    end
  end

  initial begin
    control_signals_t zr, f, d, c;
    tests_run    = 0;
    tests_failed = 0;
    zr = '0;
    f  = pc_rd(1'b1);
    d  = pc_rd(1'b0);
    reset  = 1'b1;
    rdy    = 1'b1;
    opcode = 8'hEA;
    @(posedge ph0);
    #1;

    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 8'hEA, 3'd1, 0, 0, zr, "reset");
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, f, "nop_fetch");
      apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "nop_t2");
    end

    apply_stimulus(0, 1, 8'hA9, 3'd1, 1, 0, f, "imm_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, f, "imm_t2");
    c = f; c.dl_db = 1; c.ac_db = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, c, "imm_retire");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "nop_after_imm");

    apply_stimulus(0, 1, 8'hAD, 3'd1, 1, 0, f, "abs_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, f, "abs_t2");
    c = f; c.dl_db = 1; c.db_add = 1; c.z_add = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd3, 0, 0, c, "abs_t3");
    c = zr; c.dl_adh = 1; c.adh_abh = 1; c.add_adl = 1; c.adl_abl = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd4, 0, 0, c, "abs_t4");
    c = f; c.dl_db = 1; c.ac_db = 1;
    apply_stimulus(0, 1, 8'hAA, 3'd1, 1, 0, c, "abs_retire_tax_fetch");

    c = d; c.ac_out_sb = 1; c.sb_x = 1;
    apply_stimulus(0, 1, 8'h8A, 3'd2, 0, 0, c, "tax_t2");
    apply_stimulus(0, 1, 8'h8A, 3'd1, 1, 0, f, "txa_fetch");
    c = d; c.x_sb = 1; c.ac_sb = 1;
    apply_stimulus(0, 1, 8'hA5, 3'd2, 0, 0, c, "txa_t2");
    apply_stimulus(0, 1, 8'hA8, 3'd1, 1, 0, f, "tay_fetch");
    c = d; c.ac_out_sb = 1; c.sb_y = 1;
    apply_stimulus(0, 1, 8'h98, 3'd2, 0, 0, c, "tay_t2");
    apply_stimulus(0, 1, 8'h98, 3'd1, 1, 0, f, "tya_fetch");
    c = d; c.y_sb = 1; c.ac_sb = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, c, "tya_t2");

    apply_stimulus(0, 1, 8'hA5, 3'd1, 1, 0, f, "zp_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, f, "zp_t2");
    c = zr; c.dl_adl = 1; c.zero_adh = 1;
    apply_stimulus(0, 0, 8'hEA, 3'd3, 0, 0, c, "zp_t3_stall1");
    apply_stimulus(0, 0, 8'hEA, 3'd3, 0, 0, c, "zp_t3_stall2");
    c.adl_abl = 1; c.adh_abh = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd3, 0, 0, c, "zp_t3");
    c = zr; c.pc_adl = 1; c.pc_adh = 1; c.dl_db = 1;
    apply_stimulus(0, 0, 8'hEA, 3'd1, 1, 0, c, "zp_retire_stall");
    c = f; c.dl_db = 1; c.ac_db = 1;
    apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, c, "zp_retire");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "nop_after_zp");

    apply_stimulus(0, 1, 8'hAD, 3'd1, 1, 0, f, "abs2_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, f, "abs2_t2");
    apply_stimulus(1, 1, 8'hEA, 3'd3, 0, 0, zr, "reset_mid_instr");
    apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, f, "post_reset_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "post_reset_t2");

    apply_stimulus(0, 1, 8'h02, 3'd1, 1, 0, f, "undef_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "undef_t2");
`ifdef K6502_JAM_EN
    apply_stimulus(0, 1, 8'hEA, 3'd0, 0, 1, zr, "jam1");
    apply_stimulus(0, 0, 8'hEA, 3'd0, 0, 1, zr, "jam2_stall");
    apply_stimulus(0, 1, 8'hEA, 3'd0, 0, 1, zr, "jam3");
    apply_stimulus(1, 1, 8'hEA, 3'd0, 0, 1, zr, "jam_reset");
    apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, f, "jam_recover_fetch");
`else
    apply_stimulus(0, 1, 8'hEA, 3'd1, 1, 0, f, "undef_back_fetch");
    apply_stimulus(0, 1, 8'hEA, 3'd2, 0, 0, d, "undef_back_t2");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ph0);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
